// File: rtl/layers_sched.sv
// Command scheduler for the layers engine: writes one layer config word, streams
// beats*outs image beats with img_last framing, then waits for outs results.
module layers_sched #(
    parameter int                    CFG_DWIDTH = 32,
    parameter int                    CFG_AWIDTH = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_ADDR   = 5'd4,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CFG_DWIDTH-1:0] cmd_data,
    input  logic [CNT_WIDTH-1:0]  cmd_beats,
    input  logic [CNT_WIDTH-1:0]  cmd_outs,
    input  logic                  cmd_val,
    output logic                  cmd_rdy,
    input  logic                  abort,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic                  cfg_valid,
    input  logic                  src_val,
    output logic                  src_rdy,
    output logic                  img_val,
    output logic                  img_last,
    input  logic                  img_rdy,
    input  logic                  res_val,
    input  logic                  res_rdy,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {IDLE, CFG, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] beats_q;
    logic [CNT_WIDTH-1:0] outs_q;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] out_cnt;
    logic [CNT_WIDTH-1:0] res_cnt;

    logic in_run;
    logic last_beat;
    logic xfer;
    logic res_hs;
    logic leave;

    // The image path is a pure pass-through gated by state, so reset (which
    // forces IDLE asynchronously) drops img_val/src_rdy without a clock edge.
    assign in_run    = (state == RUN);
    assign last_beat = (beat_cnt == beats_q - ONE);
    assign img_val   = in_run & src_val;
    assign src_rdy   = in_run & img_rdy;
    assign img_last  = in_run & last_beat;
    assign xfer      = in_run & src_val & img_rdy;
    assign res_hs    = res_val & res_rdy;

    // Both completion and abort return to IDLE through the same path.
    assign leave = (state == DONE) ||
                   (abort && (state == CFG || state == RUN || state == DRAIN));

    // NOTE: state and registered outputs use non-blocking assignments; each
    // output is loaded with the value it must show in the destination state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_rdy   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_valid <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            beats_q   <= '0;
            outs_q    <= '0;
            beat_cnt  <= '0;
            out_cnt   <= '0;
            res_cnt   <= '0;
        end else begin
            cfg_valid <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            done      <= 1'b0;

            if (leave) begin
                state    <= IDLE;
                busy     <= 1'b0;
                cmd_rdy  <= 1'b1;
                beat_cnt <= '0;
                out_cnt  <= '0;
                res_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_val && cmd_rdy) begin
                            beats_q   <= (cmd_beats == '0) ? ONE : cmd_beats;
                            outs_q    <= (cmd_outs == '0) ? ONE : cmd_outs;
                            beat_cnt  <= '0;
                            out_cnt   <= '0;
                            res_cnt   <= '0;
                            cfg_valid <= 1'b1;
                            cfg_addr  <= CFG_ADDR;
                            cfg_data  <= cmd_data;
                            cmd_rdy   <= 1'b0;
                            busy      <= 1'b1;
                            state     <= CFG;
                        end else begin
                            cmd_rdy <= 1'b1;
                        end
                    end
                    CFG: state <= RUN;
                    RUN, DRAIN: begin
                        // Results may arrive while beats are still streaming.
                        if (res_hs && res_cnt != outs_q)
                            res_cnt <= res_cnt + ONE;
                        if (state == RUN) begin
                            if (xfer) begin
                                if (last_beat) begin
                                    beat_cnt <= '0;
                                    out_cnt  <= out_cnt + ONE;
                                    if (out_cnt == outs_q - ONE)
                                        state <= DRAIN;
                                end else begin
                                    beat_cnt <= beat_cnt + ONE;
                                end
                            end
                        end else if (res_cnt == outs_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layers_sched.sv
// Scoreboard bench for layers_sched: a command-level model queues expected config
// writes, img_last framing and done pulses; a negedge monitor compares them.
module tb_layers_sched;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cmd_data;
    logic [CW-1:0] cmd_beats;
    logic [CW-1:0] cmd_outs;
    logic          cmd_val;
    logic          cmd_rdy;
    logic          abort;
    logic [DW-1:0] cfg_data;
    logic [AW-1:0] cfg_addr;
    logic          cfg_valid;
    logic          src_val;
    logic          src_rdy;
    logic          img_val;
    logic          img_last;
    logic          img_rdy;
    logic          res_val;
    logic          res_rdy;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    layers_sched #(
        .CFG_DWIDTH(DW),
        .CFG_AWIDTH(AW),
        .CFG_ADDR  (5'd4),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_data (cmd_data),
        .cmd_beats(cmd_beats),
        .cmd_outs (cmd_outs),
        .cmd_val  (cmd_val),
        .cmd_rdy  (cmd_rdy),
        .abort    (abort),
        .cfg_data (cfg_data),
        .cfg_addr (cfg_addr),
        .cfg_valid(cfg_valid),
        .src_val  (src_val),
        .src_rdy  (src_rdy),
        .img_val  (img_val),
        .img_last (img_last),
        .img_rdy  (img_rdy),
        .res_val  (res_val),
        .res_rdy  (res_rdy),
        .busy     (busy),
        .done     (done)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_cfg[$];
    bit          exp_last[$];
    int          exp_done    = 0;
    int          xfer_seen   = 0;
    logic        cfg_prev    = 1'b0;
    logic        done_prev   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst) begin
            if (cfg_valid) begin
                check("cfg_addr", 64'(cfg_addr), 64'd4);
                check("cfg_single", 64'(cfg_prev), 64'd0);
                if (exp_cfg.size() == 0) check("cfg_expected", 64'(cfg_valid), 64'd0);
                else check("cfg_data", 64'(cfg_data), 64'(exp_cfg.pop_front()));
            end else begin
                check("cfg_idle_zero", 64'({cfg_addr, cfg_data}), 64'd0);
            end
            if (img_val && img_rdy) begin
                xfer_seen++;
                if (exp_last.size() == 0) check("xfer_expected", 64'(img_val & img_rdy), 64'd0);
                else check("img_last", 64'(img_last), 64'(exp_last.pop_front()));
            end
            if (done) begin
                check("done_single", 64'(done_prev), 64'd0);
                if (exp_done == 0) check("done_expected", 64'(done), 64'd0);
                else begin
                    exp_done--;
                    check("done_busy", 64'(busy), 64'd1);
                end
            end
            cfg_prev  = cfg_valid;
            done_prev = done;
        end else begin
            cfg_prev  = 1'b0;
            done_prev = 1'b0;
        end
    end

    task automatic accept(input logic [31:0] data, input int beats, input int outs);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!cmd_rdy && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("cmd_rdy_wait", 64'(cmd_rdy), 64'd1);
        exp_cfg.push_back(data);
        cmd_data  = data;
        cmd_beats = CW'(beats);
        cmd_outs  = CW'(outs);
        cmd_val   = 1'b1;
        @(posedge clk);
        #1;
        cmd_val   = 1'b0;
        cmd_data  = $urandom;
        cmd_beats = CW'($urandom_range(0, 9));
        cmd_outs  = CW'($urandom_range(0, 9));
        check("busy_after_accept", 64'(busy), 64'd1);
        check("cmd_rdy_after_accept", 64'(cmd_rdy), 64'd0);
    endtask

    // flow: 0 = always ready, 1 = img_rdy toggles, 2 = random; res_delay > 0 holds
    // results off until that many cycles after the last beat.
    task automatic run_cmd(input logic [31:0] data, input int beats, input int outs,
                           input int flow, input int res_delay);
        int eb, eo, target, res_sent, budget, idle_cnt;
        bit tog, res_ok;
        eb = (beats == 0) ? 1 : beats;
        eo = (outs == 0) ? 1 : outs;
        target = eb * eo;
        for (int o = 0; o < eo; o++)
            for (int b = 0; b < eb; b++)
                exp_last.push_back(b == eb - 1);
        xfer_seen = 0;
        accept(data, beats, outs);
        res_sent = 0;
        budget   = 0;
        idle_cnt = 0;
        tog      = 1'b1;
        while ((xfer_seen < target || res_sent < eo) && budget < 800) begin
            case (flow)
                0: begin src_val = 1'b1; img_rdy = 1'b1; end
                1: begin src_val = 1'b1; img_rdy = tog; tog = ~tog; end
                default: begin
                    src_val = 1'($urandom_range(0, 1));
                    img_rdy = 1'($urandom_range(0, 1));
                end
            endcase
            if (xfer_seen >= target) begin
                src_val = 1'b0;
                idle_cnt++;
            end
            res_ok  = (res_delay == 0) ? (xfer_seen >= 1) : (idle_cnt > res_delay);
            res_val = 1'($urandom_range(0, 1));
            res_rdy = (res_ok && res_sent < eo) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (res_val && res_rdy) res_sent++;
            if (res_delay > 0 && idle_cnt == res_delay) check("drain_wait_busy", 64'(busy), 64'd1);
            #1;
            if (xfer_seen >= 1 && xfer_seen + 1 < target) begin
                check("img_val_follow", 64'(img_val), 64'(src_val));
                check("src_rdy_follow", 64'(src_rdy), 64'(img_rdy));
            end
            @(posedge clk);
            #1;
            budget++;
        end
        check("run_budget", 64'(budget < 800), 64'd1);
        src_val = 1'b0;
        img_rdy = 1'b0;
        res_val = 1'b0;
        res_rdy = 1'b0;
        exp_done++;
        budget = 0;
        @(negedge clk);
        while (!done && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("idle_done_low", 64'(done), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, want summary before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        cmd_data  = '0;
        cmd_beats = '0;
        cmd_outs  = '0;
        cmd_val   = 1'b0;
        abort     = 1'b0;
        src_val   = 1'b1;
        img_rdy   = 1'b1;
        res_val   = 1'b0;
        res_rdy   = 1'b0;

        #12;
        check("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cfg", 64'({cfg_valid, cfg_addr, cfg_data}), 64'd0);
        check("rst_img", 64'({img_val, src_rdy, img_last}), 64'd0);
        @(negedge clk);
        rst     = 1'b1;
        src_val = 1'b0;
        img_rdy = 1'b0;
        #1;
        check("cmd_rdy_before_edge", 64'(cmd_rdy), 64'd0);
        @(posedge clk);
        #1;
        check("cmd_rdy_first_edge", 64'(cmd_rdy), 64'd1);

        // Reference command, results held off for 30 cycles in DRAIN.
        run_cmd(32'h0001_0F00, 2, 2, 0, 30);
        // Zero beats/outs behave as one beat, one output.
        run_cmd($urandom, 0, 0, 0, 0);
        // img_rdy toggling, three beats.
        run_cmd($urandom, 3, 1, 1, 0);

        // Abort after the first of four beats.
        xfer_seen = 0;
        exp_last.push_back(1'b0);
        accept(32'hA5A5_0001, 4, 4);
        src_val = 1'b1;
        img_rdy = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort   = 1'b1;
        src_val = 1'b0;
        @(posedge clk);
        #1;
        abort   = 1'b0;
        img_rdy = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check("abort_one_beat", 64'(xfer_seen), 64'd1);
        check("abort_no_done", 64'(done), 64'd0);
        run_cmd(32'h0000_1234, 2, 1, 0, 0);

        // Abort during CFG still presents the config write.
        accept(32'hC0DE_0002, 2, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("cfg_abort_busy", 64'(busy), 64'd0);
        check("cfg_abort_cmd_rdy", 64'(cmd_rdy), 64'd1);

        for (int n = 0; n < 25; n++)
            run_cmd($urandom, $urandom_range(0, 5), $urandom_range(0, 4),
                    $urandom_range(0, 2), $urandom_range(0, 1) * $urandom_range(1, 6));

        // Reset asserted mid-RUN acts without a clock edge.
        xfer_seen = 0;
        accept(32'hDEAD_BEEF, 4, 2);
        src_val = 1'b1;
        img_rdy = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("run_img_val", 64'(img_val), 64'd1);
        check("run_src_rdy_low", 64'(src_rdy), 64'd0);
        img_rdy = 1'b1;
        #1;
        check("run_src_rdy", 64'(src_rdy), 64'd1);
        rst = 1'b0;
        #1;
        check("async_img_val", 64'(img_val), 64'd0);
        check("async_src_rdy", 64'(src_rdy), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_cmd_rdy", 64'(cmd_rdy), 64'd0);
        @(negedge clk);
        rst     = 1'b1;
        src_val = 1'b0;
        img_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_cmd_rdy", 64'(cmd_rdy), 64'd1);

        check("pending_last", 64'(exp_last.size()), 64'd0);
        check("pending_cfg", 64'(exp_cfg.size()), 64'd0);
        check("pending_done", 64'(exp_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layers_sched.md
LAYERS_SCHED -- requirements
Module: layers_sched

Interface
REQ-001 SHALL have parameter CFG_DWIDTH, default 32, config word width.
REQ-002 SHALL have parameter CFG_AWIDTH, default 5, config address width.
REQ-003 SHALL have parameter CFG_ADDR, default 5'd4, config address of the layers register.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, beat/output counter width.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_data  in  CFG_DWIDTH  layer config word {bypass, pool_nb, shift, head}.
- cmd_beats  in  CNT_WIDTH  image beats per output.
- cmd_outs  in  CNT_WIDTH  outputs per command.
- cmd_val  in  1  command valid.
- cmd_rdy  out  1  command accept.
- abort  in  1  synchronous abort request.
- cfg_data  out  CFG_DWIDTH  config write data.
- cfg_addr  out  CFG_AWIDTH  config write address.
- cfg_valid  out  1  config write strobe.
- src_val  in  1  upstream image beat valid.
- src_rdy  out  1  upstream image beat accept.
- img_val  out  1  image_val to layers.
- img_last  out  1  image_last to layers.
- img_rdy  in  1  image_rdy from layers.
- res_val  in  1  result_val from layers (monitor only).
- res_rdy  in  1  result_rdy to layers (monitor only).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement states IDLE, CFG, RUN, DRAIN, DONE; reset state IDLE.
REQ-007 IDLE: cmd_rdy=1; on cmd_val&cmd_rdy latch cmd_data, beats, outs; go to CFG next cycle.
REQ-008 Latched beats or outs of 0 SHALL be replaced by 1.
REQ-009 CFG: exactly one cycle, cfg_valid=1, cfg_addr=CFG_ADDR, cfg_data=latched word; then RUN.
REQ-010 Outside CFG, cfg_valid, cfg_addr, cfg_data SHALL be 0.
REQ-011 RUN: img_val=src_val, src_rdy=img_rdy, combinational, zero latency; transfer = src_val&img_rdy.
REQ-012 Other states: img_val=0, src_rdy=0, img_last=0.
REQ-013 img_last=1 in RUN iff beat_cnt==beats-1; beat_cnt increments per transfer, wraps to 0 on a last transfer.
REQ-014 Each last transfer increments out_cnt; the transfer making out_cnt==outs SHALL move RUN to DRAIN next cycle.
REQ-015 res_cnt SHALL increment on res_val&res_rdy in RUN and DRAIN, saturate at outs; ignored in IDLE, CFG, DONE.
REQ-016 A result handshake and a last transfer in the same cycle SHALL both be counted.
REQ-017 DRAIN: when res_cnt==outs (including a handshake reaching it that cycle, seen next cycle), go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE; cmd_rdy=0 in DONE.
REQ-019 abort=1 in CFG, RUN or DRAIN SHALL go to IDLE next cycle, clear all counters, no done pulse; abort in IDLE/DONE ignored.
REQ-020 abort in CFG SHALL still present the cfg write that cycle.
REQ-021 busy=1 in CFG, RUN, DRAIN, DONE.
REQ-022 cmd_rdy=0 in all states except IDLE; commands not accepted are held off, not dropped.

Reset
REQ-023 rst low SHALL immediately force IDLE, counters 0, and all outputs 0 including cmd_rdy.
REQ-024 cmd_rdy SHALL rise on the first clk edge after rst deasserts.
REQ-025 rst asserted mid-RUN SHALL drop img_val and src_rdy within the same cycle, without waiting for a clock edge.

Verification
REQ-026 Command {0x00010F00, beats=2, outs=2}, src_val=1, img_rdy=1 -> one cfg_valid cycle, addr 4, data 0x00010F00; 4 transfers, img_last on beats 2 and 4; DRAIN.
REQ-027 Same run, 2 res_val&res_rdy handshakes 30 cycles later -> DONE, done pulse 1 cycle, IDLE, cmd_rdy=1.
REQ-028 beats=0, outs=0 -> treated as 1/1: single transfer with img_last=1, one result completes.
REQ-029 img_rdy toggling 1,0,1,0 with beats=3 -> beat_cnt advances only on img_rdy=1; img_last on the 3rd accepted beat.
REQ-030 abort asserted after 1 of 4 beats -> IDLE next cycle, no done, next command restarts beat_cnt at 0.
REQ-031 rst low in RUN with src_val=1 -> img_val, src_rdy, busy go 0 asynchronously; cmd_rdy=1 after release.
